// File: rtl/tagged_burst_mux.sv
// -----------------------------------------------------------------------------
// tagged_burst_mux
//
// Merges several upstream non-show-ahead FIFOs into one output FIFO. Each
// stored word is tagged with the index of the channel it came from.
//
// An arbiter selects one channel, either round-robin or fixed priority with
// the lowest index first. It then reads up to BURST_LEN words from that
// channel before it arbitrates again. Reads are throttled so that the output
// FIFO can never overflow, which means no upstream word is lost or duplicated.
//
// Ports
//   clk            single clock for every register, output side included
//   reset          asynchronous, active-high
//   mode_rr        1 = round-robin, 0 = fixed priority (lowest index wins)
//   channel_en     per-channel enable mask
//   channel_rdreq  one-hot read strobes to the upstream FIFOs (combinational)
//   channel_data   packed upstream data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   channel_empty  upstream empty flags
//   fifo_rdreq     output FIFO read strobe
//   fifo_out       {channel index, data}; updates on an accepted read
//   fifo_usedw     number of stored words, 0..FIFO_DEPTH
//   fifo_empty     fifo_usedw == 0
//   fifo_full      fifo_usedw == FIFO_DEPTH
// -----------------------------------------------------------------------------
module tagged_burst_mux #(
  parameter  int CHANNELS   = 4,
  parameter  int DATA_WIDTH = 16,
  parameter  int FIFO_DEPTH = 64,
  parameter  int BURST_LEN  = 4,
  localparam int CH_W       = $clog2(CHANNELS),
  localparam int OW         = CH_W + DATA_WIDTH,
  localparam int UW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mode_rr,
  input  logic [CHANNELS-1:0]            channel_en,
  output logic [CHANNELS-1:0]            channel_rdreq,
  input  logic [DATA_WIDTH*CHANNELS-1:0] channel_data,
  input  logic [CHANNELS-1:0]            channel_empty,
  input  logic                           fifo_rdreq,
  output logic [OW-1:0]                  fifo_out,
  output logic [UW-1:0]                  fifo_usedw,
  output logic                           fifo_empty,
  output logic                           fifo_full
);

  localparam int AW    = UW - 1;
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    ST_ARB,
    ST_BURST
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;   // current grant, doubles as the RR pointer
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q;         // rdreq issued on the previous edge
  logic [CH_W-1:0]   tag_q;              // channel that the in-flight read belongs to
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [UW-1:0]     usedw_q;
  logic [OW-1:0]     out_q;
  logic [OW-1:0]     mem [FIFO_DEPTH];

  logic [CHANNELS-1:0] req;
  logic [CH_W-1:0]     arb_grant;
  logic [UW:0]         occupancy;
  logic                room;
  logic                wr_en, rd_en;
  logic [OW-1:0]       wr_word;

  assign req = channel_en & ~channel_empty;

  // The word being read now is still in flight, so it must be counted
  // against the free space before another read is issued.
  assign occupancy = {1'b0, usedw_q} + (UW + 1)'(inflight_q);
  assign room      = occupancy < (UW + 1)'(FIFO_DEPTH);

  // Both searches run from the least preferred candidate to the most
  // preferred one. The last hit therefore wins, and no found-flag is needed.
  always_comb begin
    arb_grant = '0;
    if (mode_rr) begin
      for (int k = CHANNELS; k >= 1; k--) begin
        if (req[(int'(grant_q) + k) % CHANNELS]) begin
          arb_grant = CH_W'((int'(grant_q) + k) % CHANNELS);
        end
      end
    end else begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (req[i]) arb_grant = CH_W'(i);
      end
    end
  end

  // NOTE: every signal gets a default before the case statement. If a path
  // left one of them unassigned, synthesis would infer a latch.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    channel_rdreq = '0;
    unique case (state_q)
      ST_ARB: begin
        if (|req) begin
          grant_d = arb_grant;
          cnt_d   = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!channel_en[grant_q] || channel_empty[grant_q]) begin
          state_d = ST_ARB;
        end else if (room) begin
          channel_rdreq[grant_q] = 1'b1;
          cnt_d                  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BURST_LEN - 1)) state_d = ST_ARB;
        end
        // When there is no room the burst simply waits and keeps its grant.
      end
      default: state_d = ST_ARB;
    endcase
  end

  // The upstream FIFO presents the data one edge after the rdreq edge. The
  // word is therefore written on that later edge, tagged with the grant that
  // issued the read.
  assign wr_en   = inflight_q;
  assign rd_en   = fifo_rdreq && (usedw_q != '0);
  assign wr_word = {tag_q, channel_data[int'(tag_q) * DATA_WIDTH +: DATA_WIDTH]};

  // NOTE: state is updated with non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the order of the
  // statements.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ARB;
      grant_q    <= CH_W'(CHANNELS - 1);
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usedw_q    <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      inflight_q <= |channel_rdreq;
      tag_q      <= grant_q;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        out_q    <= mem[rd_ptr_q];
      end
      unique case ({wr_en, rd_en})
        2'b10:   usedw_q <= usedw_q + UW'(1);
        2'b01:   usedw_q <= usedw_q - UW'(1);
        default: usedw_q <= usedw_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset. The pointers and usedw define which
  // entries are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_word;
  end

  assign fifo_out   = out_q;
  assign fifo_usedw = usedw_q;
  assign fifo_empty = (usedw_q == '0);
  assign fifo_full  = (usedw_q == UW'(FIFO_DEPTH));

endmodule

// File: tb/tb_tagged_burst_mux.sv
// -----------------------------------------------------------------------------
// tb_tagged_burst_mux
//
// Directed bench for tagged_burst_mux with its default parameters.
//
// The upstream FIFOs are modelled as per-channel counters. Channel c,
// word w, carries the data {c[3:0], w[11:0]}. An expected output word is
// therefore {c[1:0], c[3:0], w[11:0]}.
//
// Inputs are driven on the falling edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_tagged_burst_mux;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int FD = 64;
  localparam int BL = 4;
  localparam int OW = 18;
  localparam int UW = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode_rr;
  logic [CH-1:0]     channel_en;
  logic [CH-1:0]     channel_rdreq;
  logic [DW*CH-1:0]  channel_data;
  logic [CH-1:0]     channel_empty;
  logic              fifo_rdreq;
  logic [OW-1:0]     fifo_out;
  logic [UW-1:0]     fifo_usedw;
  logic              fifo_empty;
  logic              fifo_full;

  int vec_cnt = 0;
  int err_cnt = 0;

  int         up_len [CH];
  int         up_rd  [CH];
  logic       up_clr;
  bit         up_bad = 1'b0;

  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] got_q [$];

  tagged_burst_mux #(
    .CHANNELS  (CH),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD),
    .BURST_LEN (BL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mode_rr      (mode_rr),
    .channel_en   (channel_en),
    .channel_rdreq(channel_rdreq),
    .channel_data (channel_data),
    .channel_empty(channel_empty),
    .fifo_rdreq   (fifo_rdreq),
    .fifo_out     (fifo_out),
    .fifo_usedw   (fifo_usedw),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full)
  );

  always #5 clk = ~clk;

  // Upstream FIFO model (non-show-ahead). It flags reads while empty and
  // read strobes that are not one-hot.
  always @(posedge clk) begin
    if (up_clr) begin
      for (int i = 0; i < CH; i++) up_rd[i] <= 0;
    end else begin
      if ($countones(channel_rdreq) > 1) up_bad <= 1'b1;
      for (int i = 0; i < CH; i++) begin
        if (channel_rdreq[i]) begin
          if (up_rd[i] >= up_len[i]) up_bad <= 1'b1;
          channel_data[i*DW +: DW] <= {4'(i), 12'(up_rd[i])};
          up_rd[i] <= up_rd[i] + 1;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) channel_empty[i] = (up_rd[i] >= up_len[i]);
  end

  function automatic logic [OW-1:0] word(input int ch, input int w);
    return {2'(ch), 4'(ch), 12'(w)};
  endfunction

  task automatic load(input int l0, input int l1, input int l2, input int l3);
    up_len[0] = l0; up_len[1] = l1; up_len[2] = l2; up_len[3] = l3;
  endtask

  task automatic apply_reset();
    reset      = 1'b1;
    fifo_rdreq = 1'b0;
    up_clr     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    up_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reads up to n words into got_q, giving up after budget cycles. It then
  // idles briefly so that any stray extra word would show up in fifo_usedw.
  task automatic drain(input int n, input int budget);
    int   cyc;
    logic was_ne;
    got_q.delete();
    cyc = 0;
    while (got_q.size() < n && cyc < budget) begin
      was_ne     = !fifo_empty;
      fifo_rdreq = 1'b1;
      @(negedge clk);
      cyc++;
      if (was_ne) got_q.push_back(fifo_out);
    end
    fifo_rdreq = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic compare_stream(input string name);
    vec_cnt++;
    if (got_q.size() !== exp_q.size()) begin
      err_cnt++;
      $display("FAIL %s count: got %0d words, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vec_cnt++;
      if (got_q[k] !== exp_q[k]) begin
        err_cnt++;
        $display("FAIL %s word %0d: got %h, expected %h", name, k, got_q[k], exp_q[k]);
      end
    end
    vec_cnt++;
    if (fifo_usedw !== UW'(0)) begin
      err_cnt++;
      $display("FAIL %s leftover usedw: got %0d, expected 0", name, fifo_usedw);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    load(0, 0, 0, 0);
    mode_rr    = 1'b1;
    channel_en = '1;
    reset      = 1'b1;
    #1;
    vec_cnt++; if (fifo_usedw !== UW'(0)) begin err_cnt++; $display("FAIL reset usedw: got %0d, expected 0", fifo_usedw); end
    vec_cnt++; if (fifo_empty !== 1'b1) begin err_cnt++; $display("FAIL reset empty: got %b, expected 1", fifo_empty); end
    vec_cnt++; if (fifo_full !== 1'b0) begin err_cnt++; $display("FAIL reset full: got %b, expected 0", fifo_full); end
    vec_cnt++; if (fifo_out !== OW'(0)) begin err_cnt++; $display("FAIL reset fifo_out: got %h, expected 0", fifo_out); end
    vec_cnt++; if (channel_rdreq !== 4'b0000) begin err_cnt++; $display("FAIL reset rdreq: got %b, expected 0000", channel_rdreq); end
    apply_reset();
    repeat (5) @(negedge clk);
    vec_cnt++; if (channel_rdreq !== 4'b0000 || fifo_empty !== 1'b1) begin
      err_cnt++; $display("FAIL idle: rdreq %b empty %b, expected 0000 1", channel_rdreq, fifo_empty);
    end
  endtask

  task automatic test_round_robin();
    int b;
    mode_rr = 1'b1; channel_en = '1;
    load(8, 8, 8, 8);
    apply_reset();
    for (int n = 0; n < 32; n++) begin
      b = n / 4;
      exp_q.push_back(word(b % 4, (b / 4) * 4 + n % 4));
    end
    drain(32, 2000);
    compare_stream("rr");
  endtask

  task automatic test_fixed_priority();
    mode_rr = 1'b0; channel_en = '1;
    load(8, 0, 8, 0);
    apply_reset();
    for (int n = 0; n < 8; n++) exp_q.push_back(word(0, n));
    for (int n = 0; n < 8; n++) exp_q.push_back(word(2, n));
    drain(16, 2000);
    compare_stream("fixed");
  endtask

  task automatic test_short_burst();
    mode_rr = 1'b1; channel_en = '1;
    load(6, 2, 2, 0);
    apply_reset();
    exp_q = '{word(0,0), word(0,1), word(0,2), word(0,3), word(1,0),
              word(1,1), word(2,0), word(2,1), word(0,4), word(0,5)};
    drain(10, 2000);
    compare_stream("short_burst");
  endtask

  task automatic test_full();
    int b;
    mode_rr = 1'b1; channel_en = '1;
    load(25, 25, 25, 25);
    apply_reset();
    repeat (300) @(negedge clk);
    vec_cnt++; if (fifo_usedw !== UW'(64)) begin err_cnt++; $display("FAIL full usedw: got %0d, expected 64", fifo_usedw); end
    vec_cnt++; if (fifo_full !== 1'b1) begin err_cnt++; $display("FAIL full flag: got %b, expected 1", fifo_full); end
    vec_cnt++; if (channel_rdreq !== 4'b0000) begin err_cnt++; $display("FAIL full rdreq: got %b, expected 0000", channel_rdreq); end
    vec_cnt++; if (up_rd[0] + up_rd[1] + up_rd[2] + up_rd[3] !== 64) begin
      err_cnt++; $display("FAIL full upstream reads: got %0d, expected 64", up_rd[0] + up_rd[1] + up_rd[2] + up_rd[3]);
    end
    for (int n = 0; n < 96; n++) begin
      b = n / 4;
      exp_q.push_back(word(b % 4, (b / 4) * 4 + n % 4));
    end
    for (int c = 0; c < 4; c++) exp_q.push_back(word(c, 24));
    drain(100, 3000);
    compare_stream("full_drain");
  endtask

  task automatic test_disable_mid_burst();
    int seen;
    mode_rr = 1'b1; channel_en = '1;
    load(8, 2, 0, 0);
    apply_reset();
    seen = 0;
    for (int cyc = 0; cyc < 50 && seen < 2; cyc++) begin
      @(negedge clk);
      if (channel_rdreq[0]) seen++;
    end
    vec_cnt++; if (seen !== 2) begin err_cnt++; $display("FAIL disable setup: saw %0d reads, expected 2", seen); end
    @(negedge clk);
    channel_en = 4'b1110;
    #1;
    vec_cnt++; if (channel_rdreq[0] !== 1'b0) begin err_cnt++; $display("FAIL disable rdreq0: got %b, expected 0", channel_rdreq[0]); end
    exp_q = '{word(0,0), word(0,1), word(1,0), word(1,1)};
    drain(4, 500);
    vec_cnt++; if (up_rd[0] !== 2) begin err_cnt++; $display("FAIL disable ch0 reads: got %0d, expected 2", up_rd[0]); end
    compare_stream("disable");
    channel_en = '1;
  endtask

  task automatic test_reset_mid_burst();
    int seen;
    mode_rr = 1'b1; channel_en = '1;
    load(0, 0, 8, 0);
    apply_reset();
    seen = 0;
    for (int cyc = 0; cyc < 50 && seen < 3; cyc++) begin
      @(negedge clk);
      if (channel_rdreq[2]) seen++;
    end
    @(negedge clk);
    vec_cnt++; if (fifo_usedw !== UW'(2)) begin err_cnt++; $display("FAIL pre-reset usedw: got %0d, expected 2", fifo_usedw); end
    reset = 1'b1;
    #1;
    vec_cnt++; if (fifo_usedw !== UW'(0) || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
      err_cnt++; $display("FAIL midreset flags: usedw %0d empty %b full %b, expected 0 1 0", fifo_usedw, fifo_empty, fifo_full);
    end
    vec_cnt++; if (channel_rdreq !== 4'b0000) begin err_cnt++; $display("FAIL midreset rdreq: got %b, expected 0000", channel_rdreq); end
    repeat (2) @(negedge clk);
    vec_cnt++; if (up_rd[2] !== 3) begin err_cnt++; $display("FAIL midreset upstream reads: got %0d, expected 3", up_rd[2]); end
    reset = 1'b0;
    for (int w = 3; w < 8; w++) exp_q.push_back(word(2, w));
    drain(5, 500);
    compare_stream("midreset");
  endtask

  initial begin
    reset = 1'b1; mode_rr = 1'b1; channel_en = '1; fifo_rdreq = 1'b0; up_clr = 1'b1;
    load(0, 0, 0, 0);
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_short_burst();
    test_full();
    test_disable_mid_burst();
    test_reset_mid_burst();
    test_reset();
    vec_cnt++;
    if (up_bad !== 1'b0) begin
      err_cnt++; $display("FAIL upstream protocol: bad read seen %b, expected 0", up_bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tagged_burst_mux.md
TAGGED_BURST_MUX -- requirements
Module: tagged_burst_mux

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of upstream channels, legal range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, upstream word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 64, output FIFO words, power of 2, minimum 4.
REQ-004 SHALL have parameter BURST_LEN, default 4, maximum words read per grant, minimum 1.
REQ-005 SHALL define CH_W = $clog2(CHANNELS), OW = CH_W+DATA_WIDTH and UW = $clog2(FIFO_DEPTH)+1.
REQ-006 SHALL have port: reset  in  1  asynchronous, active-high.
REQ-007 SHALL have port: clk  in  1  single clock for all logic, including the output side.
REQ-008 SHALL have port: mode_rr  in  1  1 = round-robin arbitration, 0 = fixed priority with lowest index first.
REQ-009 SHALL have port: channel_en  in  CHANNELS  per-channel enable mask.
REQ-010 SHALL have port: channel_rdreq  out  CHANNELS  one-hot read strobes to the upstream FIFOs, which are non-show-ahead.
REQ-011 SHALL have port: channel_data  in  DATA_WIDTH*CHANNELS  packed upstream data, channel i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port: channel_empty  in  CHANNELS  upstream empty flags.
REQ-013 SHALL have port: fifo_rdreq  in  1  output FIFO read strobe.
REQ-014 SHALL have port: fifo_out  out  OW  {channel index, data}.
REQ-015 SHALL have port: fifo_usedw  out  UW  number of words stored, range 0..FIFO_DEPTH.
REQ-016 SHALL have port: fifo_empty  out  1  high when fifo_usedw == 0.
REQ-017 SHALL have port: fifo_full  out  1  high when fifo_usedw == FIFO_DEPTH.

Function
REQ-018 SHALL implement a two-state FSM: ARB and BURST.
REQ-019 In ARB, the request vector SHALL be req = channel_en & ~channel_empty; if req == 0, the FSM SHALL stay in ARB.
REQ-020 In ARB with req != 0, the FSM SHALL register a grant g, clear the burst counter and enter BURST on the next edge; ARB itself asserts no rdreq.
REQ-021 In round-robin mode, the search for g SHALL start at the previously granted channel+1 and wrap modulo CHANNELS; the pointer resets to CHANNELS-1, so channel 0 is searched first.
REQ-022 In fixed-priority mode, g SHALL be the lowest-index set bit of req.
REQ-023 A change of mode_rr SHALL take effect only at the next ARB cycle.
REQ-024 In BURST, channel_rdreq[g] SHALL be asserted combinationally iff channel_en[g] && !channel_empty[g] && room; all other channel_rdreq bits SHALL be 0.
REQ-025 room SHALL equal (FIFO_DEPTH - fifo_usedw - inflight) >= 1, where inflight is the registered rdreq of the previous cycle.
REQ-026 Each asserted rdreq SHALL increment the burst counter, whose width is $clog2(BURST_LEN+1).
REQ-027 BURST SHALL return to ARB after the edge on which the BURST_LEN-th rdreq is issued.
REQ-028 BURST SHALL also return to ARB on any cycle where channel_empty[g] or !channel_en[g] is high.
REQ-029 A lack of room SHALL pause the burst (no rdreq) without releasing the grant.
REQ-030 Upstream data SHALL be captured on the edge after its rdreq edge and written as {g, channel_data[g]}; the tag is the g registered with the rdreq, not the current g.
REQ-031 The output FIFO SHALL be non-show-ahead: fifo_rdreq with !fifo_empty updates fifo_out on that edge; otherwise fifo_out holds its value.
REQ-032 fifo_rdreq while empty SHALL be ignored, with no pointer or usedw change.
REQ-033 A simultaneous write and read SHALL leave fifo_usedw unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-034 The FIFO SHALL never overflow, and no upstream word SHALL be lost or duplicated.
REQ-035 Latency SHALL be: rdreq at edge E gives fifo_empty low after E+1 and fifo_out valid after E+2, given fifo_rdreq at E+1.

Reset
REQ-036 On reset: FSM = ARB, channel_rdreq = 0, inflight = 0, burst counter = 0, RR pointer = CHANNELS-1.
REQ-037 On reset: FIFO pointers = 0, fifo_usedw = 0, fifo_empty = 1, fifo_full = 0, fifo_out = 0.
REQ-038 Reset asserted mid-burst SHALL drop any in-flight word and produce no write after reset deassertion.

Verification
REQ-039 RR, CHANNELS=4, BURST_LEN=4, all channels holding 8 words -> output tags 0,0,0,0,1,1,1,1,2,...; 32 words, no loss.
REQ-040 Fixed priority, channels 0 and 2 holding 8 words each -> all 8 channel-0 words, then all 8 channel-2 words.
REQ-041 Channel 1 holding 2 words with BURST_LEN=4 -> burst ends after 2 reads, FSM back in ARB, grant moves to the next channel.
REQ-042 fifo_rdreq held low with 100 upstream words -> fifo_usedw stops at 64, fifo_full = 1, rdreq low; draining then resumes with correct ordering.
REQ-043 channel_en[g] cleared mid-burst -> no further rdreq to g; the in-flight word is still written with tag g.
REQ-044 Reset pulsed during an active burst -> all outputs at reset values, usedw = 0, and the first post-reset word is correct.
